// File: rtl/result_bus_arbiter_pkg.sv
// Shared types for the result broadcast bus: condition/exception flags, widths
// and a helper for index widths that stays legal when UNITS is 1.
package result_bus_arbiter_pkg;

  typedef struct packed {
    logic [3:0] cr0;  // lt, gt, eq, so
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;

  localparam int RS_ID_WIDTH_DEF = 5;
  localparam int GPR_ADDR_W      = 5;
  localparam int DATA_W          = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Returns one-hot grant, its index and an any-request flag.
module rr_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter for the shared result broadcast bus with a one-deep
// registered output stage feeding RS operand update and GPR writeback.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter  int UNITS       = 4,
  parameter  int RS_ID_WIDTH = RS_ID_WIDTH_DEF,
  localparam int IDX_W       = idx_w(UNITS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [UNITS-1:0]                      unit_valid,
  output logic [UNITS-1:0]                      unit_ready,
  input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]     unit_rs_id,
  input  logic [UNITS-1:0][GPR_ADDR_W-1:0]      unit_reg_addr,
  input  logic [UNITS-1:0][DATA_W-1:0]          unit_result,
  input  cond_exception_t [UNITS-1:0]           unit_cr0_xer,
  output logic                                  cdb_valid,
  input  logic                                  cdb_ready,
  output logic [RS_ID_WIDTH-1:0]                cdb_rs_id,
  output logic [GPR_ADDR_W-1:0]                 cdb_reg_addr,
  output logic [DATA_W-1:0]                     cdb_result,
  output cond_exception_t                       cdb_cr0_xer,
  output logic [IDX_W-1:0]                      cdb_unit
);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [GPR_ADDR_W-1:0]  reg_addr;
    logic [DATA_W-1:0]      result;
    cond_exception_t        cr0_xer;
  } cdb_t;

  cdb_t             stage_q, stage_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0] unit_q, unit_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [UNITS-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             req_any;
  logic             load;
  logic             grant_en;
  logic             xfer;

  rr_arbiter #(.N(UNITS), .IDX_W(IDX_W)) u_arb (
    .req (unit_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (req_any)
  );

  always_comb begin
    load        = !cdb_valid_q || cdb_ready;
    // rst term keeps ready low while reset is held, since it is asynchronous
    grant_en    = load && !flush && rst;
    unit_ready  = grant_en ? gnt : '0;
    xfer        = grant_en && req_any;
    cdb_valid_d = cdb_valid_q;
    stage_d     = stage_q;
    unit_d      = unit_q;
    ptr_d       = ptr_q;
    if (flush)     cdb_valid_d = 1'b0;
    else if (load) cdb_valid_d = req_any;
    if (xfer) begin
      stage_d.rs_id    = unit_rs_id[gnt_idx];
      stage_d.reg_addr = unit_reg_addr[gnt_idx];
      stage_d.result   = unit_result[gnt_idx];
      stage_d.cr0_xer  = unit_cr0_xer[gnt_idx];
      unit_d           = gnt_idx;
      ptr_d            = IDX_W'((int'(gnt_idx) + 1) % UNITS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      stage_q     <= '0;
      unit_q      <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      stage_q     <= stage_d;
      unit_q      <= unit_d;
      ptr_q       <= ptr_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rs_id    = stage_q.rs_id;
  assign cdb_reg_addr = stage_q.reg_addr;
  assign cdb_result   = stage_q.result;
  assign cdb_cr0_xer  = stage_q.cr0_xer;
  assign cdb_unit     = unit_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: directed scenarios then random traffic against
// a cycle-level reference model of the broadcast stage and round-robin order.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  localparam int UNITS = 4;
  localparam int RSW   = 5;

  logic                             clk, rst, flush, cdb_ready;
  logic [UNITS-1:0]                 unit_valid, unit_ready;
  logic [UNITS-1:0][RSW-1:0]        unit_rs_id;
  logic [UNITS-1:0][4:0]            unit_reg_addr;
  logic [UNITS-1:0][31:0]           unit_result;
  cond_exception_t [UNITS-1:0]      unit_cr0_xer;
  logic                             cdb_valid;
  logic [RSW-1:0]                   cdb_rs_id;
  logic [4:0]                       cdb_reg_addr;
  logic [31:0]                      cdb_result;
  cond_exception_t                  cdb_cr0_xer;
  logic [1:0]                       cdb_unit;

  result_bus_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_rs_id(unit_rs_id), .unit_reg_addr(unit_reg_addr),
    .unit_result(unit_result), .unit_cr0_xer(unit_cr0_xer),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rs_id(cdb_rs_id), .cdb_reg_addr(cdb_reg_addr),
    .cdb_result(cdb_result), .cdb_cr0_xer(cdb_cr0_xer),
    .cdb_unit(cdb_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: broadcast register contents and round-robin pointer
  bit         m_valid;
  logic [4:0] m_rs, m_reg;
  logic [31:0] m_res;
  logic [6:0] m_fl;
  int         m_unit, m_ptr, last_g;
  int         wait_cnt [UNITS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_unit(input int u);
    logic [6:0] f;
    f = 7'($urandom);
    unit_valid[u]    = 1'b1;
    unit_rs_id[u]    = RSW'($urandom);
    unit_reg_addr[u] = 5'($urandom);
    unit_result[u]   = $urandom;
    unit_cr0_xer[u]  = cond_exception_t'(f);
    wait_cnt[u]      = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rs = '0; m_reg = '0; m_res = '0; m_fl = '0;
    m_unit = 0; m_ptr = 0; last_g = -1;
    for (int u = 0; u < UNITS; u++) wait_cnt[u] = 0;
  endtask

  // one clock: check at negedge, advance model, return at posedge+1
  task automatic cycle();
    int g;
    logic [UNITS-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if ((!m_valid || cdb_ready) && !flush)
      for (int k = 0; k < UNITS; k++)
        if (g < 0 && unit_valid[(m_ptr + k) % UNITS]) g = (m_ptr + k) % UNITS;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("unit_ready", unit_ready, exp_rdy);
    chk("cdb_valid", cdb_valid, m_valid);
    if (m_valid) begin
      chk("cdb_rs_id", cdb_rs_id, m_rs);
      chk("cdb_reg_addr", cdb_reg_addr, m_reg);
      chk("cdb_result", cdb_result, m_res);
      chk("cdb_cr0_xer", cdb_cr0_xer, m_fl);
      chk("cdb_unit", cdb_unit, m_unit);
    end
    if (flush) m_valid = 0;
    else if (!m_valid || cdb_ready) begin
      if (g >= 0) begin
        m_valid = 1; m_rs = unit_rs_id[g]; m_reg = unit_reg_addr[g];
        m_res = unit_result[g]; m_fl = unit_cr0_xer[g]; m_unit = g;
        m_ptr = (g + 1) % UNITS;
        chk("no_starve", (wait_cnt[g] < UNITS) ? 1 : 0, 1);
        for (int u = 0; u < UNITS; u++)
          if (u != g && unit_valid[u]) wait_cnt[u]++;
      end else m_valid = 0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) unit_valid[g] = 1'b0;
    last_g = g;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; cdb_ready = 1'b1;
    unit_valid = '1; unit_rs_id = '0; unit_reg_addr = '0; unit_result = '0; unit_cr0_xer = '0;
    model_reset();
    #3;
    chk("rst_ready", unit_ready, 0);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_rs_id", cdb_rs_id, 0);
    chk("rst_reg", cdb_reg_addr, 0);
    chk("rst_result", cdb_result, 0);
    chk("rst_flags", cdb_cr0_xer, 0);
    chk("rst_unit", cdb_unit, 0);
    @(posedge clk); #1;
    rst = 1'b1; unit_valid = '0;

    // all units valid continuously: strict rotation, no bubbles
    for (int i = 0; i < 5; i++) begin
      for (int u = 0; u < UNITS; u++) if (!unit_valid[u]) set_unit(u);
      cycle();
      chk("rr_seq", last_g, i % UNITS);
      if (i > 0) chk("no_bubble", cdb_valid, 1);
    end
    unit_valid = '0;
    cycle();

    // single request from unit 2 (ptr is 1 here)
    set_unit(2);
    unit_rs_id[2] = 5'd5; unit_reg_addr[2] = 5'd7; unit_result[2] = 32'hDEADBEEF;
    cycle();
    chk("t1_grant", last_g, 2);
    chk("t1_valid", cdb_valid, 1);
    chk("t1_rs_id", cdb_rs_id, 5);
    chk("t1_reg", cdb_reg_addr, 7);
    chk("t1_result", cdb_result, 32'hDEADBEEF);
    chk("t1_unit", cdb_unit, 2);
    repeat (3) cycle();

    // stall: unit 1 broadcast held while 0 and 3 wait, then 3 beats 0
    set_unit(1);
    cycle();
    chk("t3_g1", last_g, 1);
    cdb_ready = 1'b0; set_unit(0); set_unit(3);
    repeat (3) begin
      cycle();
      chk("t3_hold_unit", cdb_unit, 1);
      chk("t3_hold_g", last_g, -1);
    end
    cdb_ready = 1'b1;
    cycle(); chk("t3_g3", last_g, 3);
    cycle(); chk("t3_g0", last_g, 0);

    // flush while broadcasting with unit 0 pending
    set_unit(0); flush = 1'b1;
    cycle();
    chk("flush_nog", last_g, -1);
    chk("flush_valid", cdb_valid, 0);
    flush = 1'b0;
    cycle(); chk("flush_after", last_g, 0);

    // idle cycles leave ptr at 1
    repeat (3) cycle();
    set_unit(0); set_unit(1);
    cycle(); chk("idle_g1", last_g, 1);
    cycle(); chk("idle_g0", last_g, 0);
    repeat (2) cycle();

    // asynchronous reset mid-stream
    set_unit(2);
    cycle(); chk("t5_g2", last_g, 2);
    cdb_ready = 1'b0; set_unit(0); set_unit(3);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", cdb_valid, 0);
    chk("arst_ready", unit_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1; cdb_ready = 1'b1;
    cycle(); chk("arst_g0", last_g, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int u = 0; u < UNITS; u++)
        if (!unit_valid[u] && $urandom_range(1, 0) == 0) set_unit(u);
      cdb_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(15, 0) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Shares the single result/update broadcast bus among UNITS execution-unit wrappers (logical, add, multiply, ...), each exposing a ready-valid result port.
- Selects one unit per cycle with round-robin priority and registers the winner into a one-deep output stage.
- The output stage drives the reservation-station operand-update bus and the register-file writeback.
- A flush input discards the pending broadcast on pipeline squash.

Parameters:
- UNITS, 4, number of requesting execution units (2..8).
- RS_ID_WIDTH, 5, width of reservation-station tags.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the output stage.
- unit_valid  in  UNITS  per-unit result valid.
- unit_ready  out  UNITS  per-unit result accepted.
- unit_rs_id  in  UNITS x RS_ID_WIDTH  per-unit producing RS tag.
- unit_reg_addr  in  UNITS x 5  per-unit destination GPR.
- unit_result  in  UNITS x 32  per-unit result value.
- unit_cr0_xer  in  UNITS x cond_exception_t  per-unit CR0/XER flags.
- cdb_valid  out  1  broadcast valid.
- cdb_ready  in  1  consumer accepts the broadcast.
- cdb_rs_id  out  RS_ID_WIDTH  tag being broadcast.
- cdb_reg_addr  out  5  destination GPR.
- cdb_result  out  32  result value.
- cdb_cr0_xer  out  cond_exception_t  flags.
- cdb_unit  out  clog2(UNITS)  index of the source unit.

Behaviour:
- Reset (rst=0, asynchronous): cdb_valid=0; cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer and cdb_unit all 0; priority pointer ptr=0. unit_ready=0 while in reset.
- load = !cdb_valid || cdb_ready. Combinational.
- Grant: with load=1 and flush=0, the winner is the first unit i with unit_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo UNITS.
  - Winner i gets unit_ready[i]=1; all other unit_ready bits are 0.
  - No valid unit, load=0 or flush=1: unit_ready is all 0.
- unit_ready depends on unit_valid combinationally. Units must not derive valid from ready.
- Transfer: on a clock edge with unit_valid[i] && unit_ready[i]:
  - Unit i's fields load into the output stage; cdb_unit=i; cdb_valid=1 next cycle.
  - ptr=(i+1) mod UNITS.
  - Latency is 1 cycle from unit handshake to cdb_valid.
- Hold: while cdb_valid=1 && cdb_ready=0, all cdb_* outputs hold stable, ptr holds, and no unit is granted.
- Drain: cdb_valid && cdb_ready with no new grant gives cdb_valid=0 next cycle. The data fields may hold their stale values.
- Back-to-back: cdb_ready=1 permits one broadcast per cycle at full throughput, with no bubble.
- ptr advances only on a transfer, never on idle cycles. A unit holding valid is granted within UNITS transfers (no starvation).
- Flush=1, synchronous:
  - cdb_valid=0 next cycle.
  - No grant that cycle.
  - ptr unchanged.
  - Flush has priority over cdb_ready and pending requests.
- Reset mid-transfer: the output stage is lost and cdb_valid drops immediately (asynchronous). Units see unit_ready=0 and must retain their results.
- UNITS=1 degenerates to a registered pass-through; cdb_unit is 1 bit, constant 0.

Decomposition:
- ppc_types holds a shared cdb_t struct (rs_id, reg_addr, result, cr0_xer) parameterised via RS_ID_WIDTH. Alternatively it holds a localparam default and the struct lives in this module.
- cond_exception_t is reused from ppc_types.
- One natural sub-module, rr_arbiter: combinational round-robin grant from request vector and ptr, returning a one-hot grant and an index. It is reusable for the dispatch-port arbitration.

Test Plan:
- Reset, then unit 2 valid (rs_id=5, reg=7, result=0xDEADBEEF): unit_ready[2]=1 same cycle; next cycle cdb_valid=1, cdb_rs_id=5, cdb_reg_addr=7, cdb_result=0xDEADBEEF, cdb_unit=2, ptr=3.
- All 4 units valid continuously, cdb_ready=1: grants 0,1,2,3,0 on consecutive cycles, one broadcast per cycle, no bubbles.
- Unit 1 broadcast with cdb_ready=0 for 3 cycles while units 0 and 3 are valid: cdb fields are stable and unit_ready=0 throughout. cdb_ready=1 grants unit 3 (ptr=2, so 3 beats 0), then unit 0.
- Flush asserted while cdb_valid=1 and unit 0 valid: next cycle cdb_valid=0; unit_ready[0]=0 in the flush cycle; unit 0 is granted the cycle after flush drops.
- rst pulled low mid-stream with cdb_valid=1: cdb_valid=0 and unit_ready=0 immediately. After release ptr=0, and unit 0 wins over unit 3 when both are valid.
- Idle cycles between requests: ptr stays at its post-grant value. Unit 1 alone after unit 0's grant is served next cycle.
